// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and staggered domain reset release
module pll_lock_supervisor #(
    parameter int CHANNELS       = 4,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RESET_PULSE    = 16,
    parameter int STAGGER        = 8,
    parameter int CNT_W          = 8
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                lock_i,
    input  logic                force_relock,
    input  logic                clear_count,
    output logic                pll_reset,
    output logic [CHANNELS-1:0] rst_out,
    output logic                locked,
    output logic [CNT_W-1:0]    relock_count,
    output logic                timeout_err
);

    localparam int REL_LAST = (CHANNELS - 1) * STAGGER;
    localparam int MAX_A    = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
    localparam int MAX_B    = (MAX_A > RESET_PULSE) ? MAX_A : RESET_PULSE;
    localparam int MAX_C    = (MAX_B > REL_LAST + 2) ? MAX_B : REL_LAST + 2;
    localparam int CW       = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          lock_s;
    logic          lock_lost;
    logic          timeout_hit;
    logic          go_rst;

    // Lock loss outranks force_relock so a coincident request still gets counted.
    always_comb begin
        lock_lost   = 1'b0;
        timeout_hit = 1'b0;
        go_rst      = 1'b0;
        if ((state == RELEASE || state == RUN) && !lock_s) begin
            lock_lost = 1'b1;
        end
        if (state == WAIT_LOCK && !force_relock && !lock_s &&
            cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
        end
        if (lock_lost || timeout_hit || (force_relock && state != PLL_RST)) begin
            go_rst = 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state        <= PLL_RST;
            cnt          <= '0;
            sync1        <= 1'b0;
            lock_s       <= 1'b0;
            pll_reset    <= 1'b1;
            rst_out      <= '1;
            locked       <= 1'b0;
            relock_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            sync1  <= lock_i;
            lock_s <= sync1;
            cnt    <= cnt + 1'b1;

            if (go_rst) begin
                state     <= PLL_RST;
                cnt       <= '0;
                pll_reset <= 1'b1;
                rst_out   <= '1;
                locked    <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == CW'(RESET_PULSE - 1)) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end
                    end
                    RELEASE: begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (cnt == CW'(k * STAGGER)) begin
                                rst_out[k] <= 1'b0;
                            end
                        end
                        if (cnt == CW'(REL_LAST + 1)) begin
                            state  <= RUN;
                            cnt    <= '0;
                            locked <= 1'b1;
                        end
                    end
                    RUN: begin
                        locked <= 1'b1;
                    end
                    default: begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        rst_out   <= '1;
                        locked    <= 1'b0;
                    end
                endcase
            end

            // A same-cycle clear wins over both the increment and the sticky set.
            if (clear_count) begin
                relock_count <= '0;
                timeout_err  <= 1'b0;
            end else begin
                if (lock_lost && relock_count != '1) begin
                    relock_count <= relock_count + 1'b1;
                end
                if (timeout_hit) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed table and sequence checks for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          lock_i;
    logic          force_relock;
    logic          clear_count;
    logic          pll_reset;
    logic [CH-1:0] rst_out;
    logic          locked;
    logic [1:0]    relock_count;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(64),
        .RESET_PULSE   (4),
        .STAGGER       (2),
        .CNT_W         (2)
    ) dut (
        .clkin       (clk),
        .reset       (reset),
        .lock_i      (lock_i),
        .force_relock(force_relock),
        .clear_count (clear_count),
        .pll_reset   (pll_reset),
        .rst_out     (rst_out),
        .locked      (locked),
        .relock_count(relock_count),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int         cyc;
        logic       lock;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [7:0] mk(input logic p, input logic [2:0] r, input logic l,
                                      input logic [1:0] c, input logic e);
        return {p, r, l, c, e};
    endfunction

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {pll_reset, rst_out, locked, relock_count, timeout_err};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got pll_reset=%b rst_out=%b locked=%b relock_count=%0d timeout_err=%b, want %b %b %b %0d %b",
                     name, cyc, act[7], act[6:4], act[3], act[2:1], act[0],
                     exp[7], exp[6:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        lock_i       = 1'b0;
        force_relock = 1'b0;
        clear_count  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Drop lock from RUN, let it return 8 cycles later, and check the re-lock lands in RUN.
    task automatic loss_relock(input logic [1:0] exp_cnt, input string nm);
        int d;
        d      = cyc;
        lock_i = 1'b0;
        goto(d + 3);
        chk({nm, "_drop"}, mk(1'b1, 3'b111, 1'b0, exp_cnt, 1'b0));
        goto(d + 8);
        lock_i = 1'b1;
        goto(d + 25);
        chk({nm, "_run"}, mk(1'b0, 3'b000, 1'b1, exp_cnt, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int d;
        tbl[0]  = '{0,  1'b0, mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[1]  = '{3,  1'b0, mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[2]  = '{4,  1'b0, mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[3]  = '{10, 1'b1, mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[4]  = '{20, 1'b1, mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[5]  = '{21, 1'b1, mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0)};
        tbl[6]  = '{22, 1'b1, mk(1'b0, 3'b110, 1'b0, 2'd0, 1'b0)};
        tbl[7]  = '{23, 1'b1, mk(1'b0, 3'b110, 1'b0, 2'd0, 1'b0)};
        tbl[8]  = '{24, 1'b1, mk(1'b0, 3'b100, 1'b0, 2'd0, 1'b0)};
        tbl[9]  = '{26, 1'b1, mk(1'b0, 3'b000, 1'b0, 2'd0, 1'b0)};
        tbl[10] = '{27, 1'b1, mk(1'b0, 3'b000, 1'b1, 2'd0, 1'b0)};
        tbl[11] = '{30, 1'b1, mk(1'b0, 3'b000, 1'b1, 2'd0, 1'b0)};

        // Power-up sequence from the table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            goto(tbl[i].cyc);
            chk($sformatf("powerup_c%0d", tbl[i].cyc), tbl[i].exp);
            lock_i = tbl[i].lock;
        end

        // Glitchy lock restarts the stability window.
        do_reset();
        goto(10); lock_i = 1'b1;
        goto(15); lock_i = 1'b0;
        goto(16); lock_i = 1'b1;
        goto(22); chk("glitch_no_early_release", mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(27); chk("glitch_release_entry",    mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(28); chk("glitch_first_release",    mk(1'b0, 3'b110, 1'b0, 2'd0, 1'b0));
        goto(33); chk("glitch_run",              mk(1'b0, 3'b000, 1'b1, 2'd0, 1'b0));

        // Timeout retry with lock never arriving.
        do_reset();
        goto(67);  chk("to_before",       mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(68);  chk("to_first",        mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b1));
        goto(71);  chk("to_pulse_end",    mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b1));
        goto(72);  chk("to_wait_again",   mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b1));
        goto(135); chk("to_before_2nd",   mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b1));
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        chk("to_clear_beats_set", mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(140); chk("to_wait_3rd",     mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(203); chk("to_before_3rd",   mk(1'b0, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(204); chk("to_third",        mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b1));

        // Lock loss in RUN, repeated to saturation, then a reset during RELEASE.
        do_reset();
        goto(10); lock_i = 1'b1;
        goto(30); chk("loss_in_run", mk(1'b0, 3'b000, 1'b1, 2'd0, 1'b0));
        loss_relock(2'd1, "loss1");
        loss_relock(2'd2, "loss2");
        loss_relock(2'd3, "loss3");
        loss_relock(2'd3, "loss4_sat");
        loss_relock(2'd3, "loss5_sat");
        d      = cyc;
        lock_i = 1'b0;
        goto(d + 8);  lock_i = 1'b1;
        goto(d + 22); chk("midreset_before", mk(1'b0, 3'b100, 1'b0, 2'd3, 1'b0));
        reset = 1'b1;
        tick();
        chk("midreset_after", mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0));
        reset = 1'b0;

        // force_relock versus lock loss, and clear_count against an increment.
        do_reset();
        goto(10); lock_i = 1'b1;
        goto(30); force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        chk("force_no_count", mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0));
        goto(50); chk("force_relocked", mk(1'b0, 3'b000, 1'b1, 2'd0, 1'b0));
        goto(52); lock_i = 1'b0;
        goto(54); force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        chk("force_with_loss", mk(1'b1, 3'b111, 1'b0, 2'd1, 1'b0));
        goto(60); lock_i = 1'b1;
        goto(77); chk("force_run_again", mk(1'b0, 3'b000, 1'b1, 2'd1, 1'b0));
        goto(80); lock_i = 1'b0;
        goto(82); clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        chk("clear_beats_inc", mk(1'b1, 3'b111, 1'b0, 2'd0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
